// File: rtl/dpc_badpoint_sequencer.sv
// Bad-pixel coordinate sequencer for the DPC filter: double-banked list, frame-synchronous swap.
// Optional DPC_SEQ_ORDER_CHECK_EN: skip entries the raster has already passed and flag order_err.
module dpc_badpoint_sequencer #(
    parameter int CNT_WIDTH      = 10,
    parameter int ADDR_BITS      = 7,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic [CNT_WIDTH-1:0]      pix_hcnt,
    input  logic [CNT_WIDTH-1:0]      pix_vcnt,
    input  logic                      cfg_wen,
    input  logic [ADDR_BITS-1:0]      cfg_waddr,
    input  logic [AXI_DATA_WIDTH-1:0] cfg_wdata,
    input  logic [ADDR_BITS:0]        cfg_num,
    input  logic                      cfg_commit,
    output logic                      bad_hit,
    output logic [CNT_WIDTH-1:0]      bad_hcnt,
    output logic [CNT_WIDTH-1:0]      bad_vcnt,
    output logic                      list_done,
    output logic                      commit_pending,
    output logic                      active_bank,
    output logic                      order_err
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int NUM_W = ADDR_BITS + 1;
    localparam int ENT_W = 2 * CNT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE0,
        S_PRE1,
        S_ARMED,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ENT_W-1:0] mem [2*DEPTH];
    logic [ENT_W-1:0] rd_data;
    logic [ADDR_BITS-1:0] rd_addr;

    logic [NUM_W-1:0] ptr_q, ptr_d;
    logic [NUM_W-1:0] ptr_p1, ptr_p2;
    logic [NUM_W-1:0] active_num_q;
    logic [NUM_W-1:0] num_eff;
    logic [ENT_W-1:0] cur_q, cur_d;
    logic [ENT_W-1:0] nxt_q, nxt_d;
    logic [ENT_W-1:0] nxt_eff;
    logic             rd_pend_q, rd_pend_d;
    logic             bank_q;
    logic             pend_q;
    logic             swap;
    logic             armed;
    logic             hit;
    logic             skip;
    logic             adv;
    logic [CNT_WIDTH-1:0] cur_h, cur_v;

    assign cur_h = cur_q[CNT_WIDTH-1:0];
    assign cur_v = cur_q[ENT_W-1:CNT_WIDTH];

    // Shadow writes and datapath reads always target opposite banks.
    always_ff @(posedge aclk) begin
        if (cfg_wen)
            mem[{~bank_q, cfg_waddr}] <= {cfg_wdata[16+CNT_WIDTH-1:16],
                                          cfg_wdata[CNT_WIDTH-1:0]};
    end

    always_ff @(posedge aclk) begin
        rd_data <= mem[{bank_q, rd_addr}];
    end

    assign swap    = frame_start & pend_q;
    assign num_eff = swap ? cfg_num : active_num_q;
    assign armed   = (state_q == S_ARMED);
    assign hit     = armed & pix_valid &
                     (pix_hcnt == cur_h) & (pix_vcnt == cur_v);

`ifdef DPC_SEQ_ORDER_CHECK_EN
    assign skip = armed & pix_valid & ~hit &
                  ((pix_vcnt > cur_v) |
                   ((pix_vcnt == cur_v) & (pix_hcnt > cur_h)));
`else
    assign skip = 1'b0;
`endif

    assign adv    = hit | skip;
    assign ptr_p1 = ptr_q + NUM_W'(1);
    assign ptr_p2 = ptr_q + NUM_W'(2);

    // A read issued last cycle holds the freshest next entry.
    assign nxt_eff = rd_pend_q ? rd_data : nxt_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        nxt_d     = nxt_eff;
        rd_pend_d = 1'b0;
        rd_addr   = ptr_p2[ADDR_BITS-1:0];
        if (frame_start) begin
            ptr_d   = '0;
            rd_addr = '0;
            state_d = (num_eff == '0) ? S_DONE : S_PRE0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_PRE0: begin
                    rd_addr = '0;
                    state_d = S_PRE1;
                end
                S_PRE1: begin
                    cur_d     = rd_data;
                    rd_addr   = ADDR_BITS'(1);
                    rd_pend_d = 1'b1;
                    state_d   = S_ARMED;
                end
                S_ARMED: begin
                    if (adv) begin
                        ptr_d     = ptr_p1;
                        cur_d     = nxt_eff;
                        rd_pend_d = 1'b1;
                        if (ptr_p1 == active_num_q)
                            state_d = S_DONE;
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cur_q     <= '0;
            nxt_q     <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // A commit landing on frame_start waits for the following frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bank_q       <= 1'b0;
            active_num_q <= '0;
            pend_q       <= 1'b0;
        end else if (swap) begin
            bank_q       <= ~bank_q;
            active_num_q <= cfg_num;
            pend_q       <= cfg_commit;
        end else if (cfg_commit) begin
            pend_q <= 1'b1;
        end
    end

`ifdef DPC_SEQ_ORDER_CHECK_EN
    logic oerr_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            oerr_q <= 1'b0;
        else if (skip)
            oerr_q <= 1'b1;
    end
    assign order_err = oerr_q;
`else
    assign order_err = 1'b0;
`endif

    assign bad_hit        = hit;
    assign bad_hcnt       = (state_q == S_IDLE) ? '0 : cur_h;
    assign bad_vcnt       = (state_q == S_IDLE) ? '0 : cur_v;
    assign list_done      = (state_q == S_DONE);
    assign commit_pending = pend_q;
    assign active_bank    = bank_q;

    logic unused_bits;
    assign unused_bits = ^{cfg_wdata, ptr_p2[ADDR_BITS]};

endmodule

// File: tb/tb_dpc_badpoint_sequencer.sv
// Testbench for dpc_badpoint_sequencer: directed table, corner sequences, random frames vs list model.
// Honours DPC_SEQ_ORDER_CHECK_EN the same way as the design.
module tb_dpc_badpoint_sequencer;

`ifdef DPC_SEQ_ORDER_CHECK_EN
    localparam bit OC = 1'b1;
`else
    localparam bit OC = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_hcnt = '0;
    logic [9:0]  pix_vcnt = '0;
    logic        cfg_wen = 1'b0;
    logic [6:0]  cfg_waddr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [7:0]  cfg_num = '0;
    logic        cfg_commit = 1'b0;
    logic        bad_hit;
    logic [9:0]  bad_hcnt;
    logic [9:0]  bad_vcnt;
    logic        list_done;
    logic        commit_pending;
    logic        active_bank;
    logic        order_err;

    dpc_badpoint_sequencer dut (
        .aclk(aclk), .aresetn(aresetn), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_hcnt(pix_hcnt), .pix_vcnt(pix_vcnt),
        .cfg_wen(cfg_wen), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
        .cfg_num(cfg_num), .cfg_commit(cfg_commit), .bad_hit(bad_hit),
        .bad_hcnt(bad_hcnt), .bad_vcnt(bad_vcnt), .list_done(list_done),
        .commit_pending(commit_pending), .active_bank(active_bank),
        .order_err(order_err)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference: two coordinate lists, a list index and a warm-up delay.
    int m_h [2][128];
    int m_v [2][128];
    int m_bank, m_num, m_pend, m_started, m_delay, m_idx, m_done, m_oerr;
    logic s_hit, s_done;
    int hit_cnt;

    int l_h [16];
    int l_v [16];
    int l_n;
    int wr_pos, wr_n;
    bit wr_commit;

    typedef struct {
        bit valid;
        int h;
        int v;
        bit hit;
        bit done;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bank = 0; m_num = 0; m_pend = 0; m_started = 0;
        m_delay = 0; m_idx = 0; m_done = 0; m_oerr = 0;
    endtask

    task automatic tick();
        bit armed, e_hit, e_skip;
        int ch, cv, wb;
        @(negedge aclk);
        armed = m_started != 0 && m_delay == 0 && m_done == 0;
        e_hit = 0; e_skip = 0; ch = 0; cv = 0;
        if (armed) begin
            ch = m_h[m_bank][m_idx];
            cv = m_v[m_bank][m_idx];
            e_hit = pix_valid && int'(pix_hcnt) == ch && int'(pix_vcnt) == cv;
            e_skip = OC && pix_valid && !e_hit &&
                     (int'(pix_vcnt) > cv || (int'(pix_vcnt) == cv && int'(pix_hcnt) > ch));
        end
        chk("bad_hit", bad_hit, e_hit);
        chk("list_done", list_done, m_done);
        chk("commit_pending", commit_pending, m_pend);
        chk("active_bank", active_bank, m_bank);
        chk("order_err", order_err, m_oerr);
        if (armed) begin
            chk("bad_hcnt", bad_hcnt, ch);
            chk("bad_vcnt", bad_vcnt, cv);
        end
        s_hit = bad_hit;
        s_done = list_done;
        hit_cnt += int'(bad_hit);
        @(posedge aclk);
        wb = 1 - m_bank;
        if (frame_start) begin
            if (m_pend != 0) begin
                m_bank = 1 - m_bank;
                m_num = int'(cfg_num);
                m_pend = int'(cfg_commit);
            end else if (cfg_commit) begin
                m_pend = 1;
            end
            m_started = 1; m_idx = 0; m_delay = 2;
            m_done = (m_num == 0);
        end else begin
            if (cfg_commit) m_pend = 1;
            if (e_hit || e_skip) begin
                m_idx++;
                if (m_idx == m_num) m_done = 1;
            end
            if (m_delay > 0) m_delay--;
            if (e_skip) m_oerr = 1;
        end
        if (cfg_wen) begin
            m_h[wb][cfg_waddr] = int'(cfg_wdata[9:0]);
            m_v[wb][cfg_waddr] = int'(cfg_wdata[25:16]);
        end
        #1;
        frame_start = 0; cfg_wen = 0; cfg_commit = 0;
    endtask

    task automatic drive_cfg();
        logic [31:0] r;
        if (wr_pos < wr_n) begin
            r = $urandom;
            cfg_wen = 1;
            cfg_waddr = 7'(wr_pos);
            r[25:16] = 10'(l_v[wr_pos]);
            r[9:0] = 10'(l_h[wr_pos]);
            cfg_wdata = r;
            wr_pos++;
        end else if (wr_commit) begin
            cfg_commit = 1;
            cfg_num = 8'(wr_n);
            wr_commit = 0;
        end
    endtask

    task automatic queue_list(input bit commit);
        wr_pos = 0; wr_n = l_n; wr_commit = commit;
    endtask

    task automatic drain();
        while (wr_pos < wr_n || wr_commit) begin
            drive_cfg();
            tick();
        end
    endtask

    task automatic start_frame();
        frame_start = 1;
        tick();
        tick();
        tick();
    endtask

    task automatic raster(input int w, input int h, input int gap, input int stop);
        int n = 0;
        for (int v = 0; v < h; v++) begin
            for (int x = 0; x < w; x++) begin
                while ($urandom_range(0, 99) < gap) begin
                    pix_valid = 0;
                    pix_hcnt = 10'($urandom_range(0, 15));
                    pix_vcnt = 10'($urandom_range(0, 7));
                    drive_cfg();
                    tick();
                end
                pix_valid = 1;
                pix_hcnt = 10'(x);
                pix_vcnt = 10'(v);
                drive_cfg();
                tick();
                n++;
                if (n == stop) begin
                    pix_valid = 0;
                    return;
                end
            end
        end
        pix_valid = 0;
        drain();
    endtask

    task automatic set2(input int h0, input int v0, input int h1, input int v1);
        l_h[0] = h0; l_v[0] = v0; l_h[1] = h1; l_v[1] = v1;
    endtask

    initial begin
        model_reset();
        hit_cnt = 0; wr_pos = 0; wr_n = 0; wr_commit = 0;
        tbl[0] = '{1, 0, 0, 0, 0};
        tbl[1] = '{1, 2, 0, 0, 0};
        tbl[2] = '{1, 2, 1, 1, 0};
        tbl[3] = '{0, 5, 1, 0, 0};
        tbl[4] = '{1, 3, 1, 0, 0};
        tbl[5] = '{1, 5, 1, 1, 0};
        tbl[6] = '{1, 6, 1, 1, 0};
        tbl[7] = '{1, 7, 1, 0, 1};
        tbl[8] = '{1, 6, 1, 0, 1};
        tbl[9] = '{1, 0, 2, 0, 1};

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_bad_hit", bad_hit, 0);
        chk("rst_bad_hcnt", bad_hcnt, 0);
        chk("rst_bad_vcnt", bad_vcnt, 0);
        chk("rst_list_done", list_done, 0);
        chk("rst_commit_pending", commit_pending, 0);
        chk("rst_active_bank", active_bank, 0);
        chk("rst_order_err", order_err, 0);
        aresetn = 1;
        tick();

        // Sorted list, table of raster positions incl. adjacent hits.
        l_n = 3; set2(2, 1, 5, 1); l_h[2] = 6; l_v[2] = 1;
        queue_list(1);
        drain();
        chk("commit_set", commit_pending, 1);
        start_frame();
        chk("swap_pending_clr", commit_pending, 0);
        chk("swap_bank", active_bank, 1);
        for (int i = 0; i < 10; i++) begin
            pix_valid = tbl[i].valid;
            pix_hcnt = 10'(tbl[i].h);
            pix_vcnt = 10'(tbl[i].v);
            tick();
            chk($sformatf("tbl%0d_hit", i), s_hit, tbl[i].hit);
            chk($sformatf("tbl%0d_done", i), s_done, tbl[i].done);
        end
        pix_valid = 0;

        // Mid-frame rewrite: current frame keeps the old list.
        start_frame();
        l_n = 2; set2(1, 2, 3, 3);
        queue_list(1);
        hit_cnt = 0;
        raster(8, 4, 0, -1);
        chk("old_list_hits", hit_cnt, 3);
        chk("mid_commit_pending", commit_pending, 1);
        start_frame();
        chk("new_pending_clr", commit_pending, 0);
        chk("new_bank", active_bank, 0);
        hit_cnt = 0;
        raster(8, 4, 20, -1);
        chk("new_list_hits", hit_cnt, 2);
        chk("new_list_done", list_done, 1);

        // Empty list.
        l_n = 0;
        queue_list(1);
        drain();
        frame_start = 1;
        tick();
        tick();
        chk("num0_done", s_done, 1);
        hit_cnt = 0;
        raster(8, 4, 0, -1);
        chk("num0_hits", hit_cnt, 0);

        // Unsorted list.
        l_n = 2; set2(5, 1, 2, 1);
        queue_list(1);
        drain();
        start_frame();
        hit_cnt = 0;
        raster(8, 4, 0, -1);
        chk("order_hits", hit_cnt, 1);
        chk("order_done", list_done, OC);
        chk("order_err_flag", order_err, OC);

        // Reset while armed after the first hit.
        start_frame();
        raster(8, 4, 0, 14);
        #2;
        aresetn = 0;
        #1;
        chk("arst_bad_hit", bad_hit, 0);
        chk("arst_bad_hcnt", bad_hcnt, 0);
        chk("arst_bad_vcnt", bad_vcnt, 0);
        chk("arst_list_done", list_done, 0);
        chk("arst_commit_pending", commit_pending, 0);
        chk("arst_active_bank", active_bank, 0);
        chk("arst_order_err", order_err, 0);
        model_reset();
        @(negedge aclk);
        aresetn = 1;
        @(posedge aclk);
        #1;
        frame_start = 1;
        tick();
        tick();
        chk("arst_num0_done", s_done, 1);

        // Random frames, lists and commits.
        for (int f = 0; f < 30; f++) begin
            int w, h, p;
            w = $urandom_range(6, 12);
            h = $urandom_range(3, 6);
            l_n = $urandom_range(0, 10);
            p = -1;
            for (int i = 0; i < l_n; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    p = p + $urandom_range(1, 6);
                    l_h[i] = p % w;
                    l_v[i] = p / w;
                end else begin
                    l_h[i] = $urandom_range(0, w + 1);
                    l_v[i] = $urandom_range(0, h);
                end
            end
            if ($urandom_range(0, 1) == 1) queue_list(1);
            frame_start = 1;
            tick();
            repeat ($urandom_range(2, 3)) tick();
            raster(w, h, $urandom_range(0, 30),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, w * h) : -1);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
